// File: rtl/pwm_multichannel_ctrl.sv
// pwm_multichannel_ctrl: N-channel PWM with double-buffered period/duty applied at period
// boundaries and an optional per-boundary duty slew limit for soft start/stop.
module pwm_multichannel_ctrl #(
   parameter int NUM_CH     = 3,
   parameter int CH_W       = 2,
   parameter int CNT_W      = 16,
   parameter int DEF_PERIOD = 10,
   parameter int RAMP_STEP  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic              wr_en_i,
   input  logic [CH_W-1:0]   wr_ch_i,
   input  logic [CNT_W-1:0]  wr_period_i,
   input  logic [CNT_W-1:0]  wr_duty_i,
   output logic              wr_err_o,
   output logic [NUM_CH-1:0] pwm_out_o,
   output logic [NUM_CH-1:0] period_start_o
);
   localparam int               CH_W1    = CH_W + 1;
   localparam int               CNT_W1   = CNT_W + 1;
   localparam logic [CH_W:0]    NUM_CH_L = CH_W1'(NUM_CH);
   localparam logic [CNT_W:0]   STEP     = CNT_W1'(RAMP_STEP);
   localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEF_PERIOD);

   logic run_q, wr_err_q, bad_ch;

   assign bad_ch   = {1'b0, wr_ch_i} >= NUM_CH_L;
   assign wr_err_o = wr_err_q;

   // run_q low means the previous edge was disabled, so the next enabled edge starts a fresh period
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run_q    <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         run_q    <= enable_i;
         wr_err_q <= wr_en_i & bad_ch;
      end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d, act_period_q, act_period_d, act_duty_q, act_duty_d;
      logic [CNT_W-1:0] pend_period_q, pend_period_d, pend_duty_q, pend_duty_d, ramped;
      logic [CNT_W:0]   up, dn;
      logic             pwm_q, pwm_d, start_q, start_d, boundary, wr_hit;

      always_comb begin
         wr_hit        = wr_en_i & ~bad_ch & (wr_ch_i == CH_W'(c));
         boundary      = ~enable_i | ~run_q | (act_period_q == '0) | (cnt_q == act_period_q - 1'b1);
         up            = {1'b0, act_duty_q} + STEP;
         dn            = ({1'b0, act_duty_q} >= STEP) ? {1'b0, act_duty_q} - STEP : '0;
         // clamping against the target prevents overshoot and also bounds the sum below 2**CNT_W
         ramped        = (STEP == '0 || !enable_i) ? pend_duty_q
                       : (pend_duty_q > act_duty_q) ? ((up > {1'b0, pend_duty_q}) ? pend_duty_q : up[CNT_W-1:0])
                       : ((dn < {1'b0, pend_duty_q}) ? pend_duty_q : dn[CNT_W-1:0]);
         cnt_d         = boundary ? '0 : cnt_q + 1'b1;
         act_period_d  = boundary ? pend_period_q : act_period_q;
         act_duty_d    = boundary ? ramped : act_duty_q;
         pend_period_d = wr_hit ? wr_period_i : pend_period_q;
         pend_duty_d   = wr_hit ? wr_duty_i : pend_duty_q;
         start_d       = boundary & enable_i & (act_period_d != '0);
         pwm_d         = enable_i & (act_period_d != '0) & (cnt_d < act_duty_d);
      end

      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            cnt_q         <= '0;
            act_period_q  <= '0;
            act_duty_q    <= '0;
            pend_period_q <= DEF_P;
            pend_duty_q   <= '0;
            pwm_q         <= 1'b0;
            start_q       <= 1'b0;
         end else begin
            cnt_q         <= cnt_d;
            act_period_q  <= act_period_d;
            act_duty_q    <= act_duty_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pwm_q         <= pwm_d;
            start_q       <= start_d;
         end

      assign pwm_out_o[c]      = pwm_q;
      assign period_start_o[c] = start_q;
   end
endmodule

// File: tb/tb_pwm_multichannel_ctrl.sv
// tb_pwm_multichannel_ctrl: directed scenarios plus randomized traffic on a direct-duty and a
// ramped (step 2) instance, checked against constants and an integer reference model.
module tb_pwm_multichannel_ctrl;
   logic        clk = 1'b0, rst_n, enable, wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_period, wr_duty;
   logic        err_a, err_b;
   logic [2:0]  pwm_a, ps_a, pwm_b, ps_b;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   pwm_multichannel_ctrl #(.NUM_CH(3), .CH_W(2), .CNT_W(16), .DEF_PERIOD(10), .RAMP_STEP(0)) u_a (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
      .wr_period_i(wr_period), .wr_duty_i(wr_duty), .wr_err_o(err_a), .pwm_out_o(pwm_a),
      .period_start_o(ps_a));

   pwm_multichannel_ctrl #(.NUM_CH(3), .CH_W(2), .CNT_W(16), .DEF_PERIOD(10), .RAMP_STEP(2)) u_b (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .wr_en_i(wr_en), .wr_ch_i(wr_ch),
      .wr_period_i(wr_period), .wr_duty_i(wr_duty), .wr_err_o(err_b), .pwm_out_o(pwm_b),
      .period_start_o(ps_b));

   // Reference model: per channel a position within the running period plus the values
   // that period uses; index 0 is the direct instance, index 1 the ramped one.
   int       m_pos[2][3], m_per[2][3], m_duty[2][3], m_nper[2][3], m_nduty[2][3];
   int       ramp_step[2] = '{0, 2};
   int       tgt;
   bit       m_run, fresh;
   logic [2:0] m_pwm[2], m_ps[2];
   logic     m_err[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0;
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
               m_pos[k][c] = 0; m_per[k][c] = 0; m_duty[k][c] = 0;
               m_nper[k][c] = 10; m_nduty[k][c] = 0;
            end
            m_pwm[k] = '0; m_ps[k] = '0; m_err[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
               fresh = !enable || !m_run || m_per[k][c] == 0 || m_pos[k][c] == m_per[k][c] - 1;
               if (fresh) begin
                  tgt = m_nduty[k][c];
                  m_pos[k][c] = 0;
                  m_per[k][c] = m_nper[k][c];
                  if (ramp_step[k] == 0 || !enable) m_duty[k][c] = tgt;
                  else if (tgt > m_duty[k][c]) m_duty[k][c] = (m_duty[k][c] + ramp_step[k] < tgt) ? m_duty[k][c] + ramp_step[k] : tgt;
                  else m_duty[k][c] = (m_duty[k][c] - ramp_step[k] > tgt) ? m_duty[k][c] - ramp_step[k] : tgt;
               end else m_pos[k][c] = m_pos[k][c] + 1;
               m_ps[k][c]  = fresh && enable && m_per[k][c] != 0;
               m_pwm[k][c] = enable && m_per[k][c] != 0 && m_pos[k][c] < m_duty[k][c];
               if (wr_en && wr_ch == c) begin
                  m_nper[k][c]  = wr_period;
                  m_nduty[k][c] = wr_duty;
               end
            end
            m_err[k] = wr_en && wr_ch >= 3;
         end
         m_run = enable;
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] ch, input int p, input int d);
      wr_en = 1; wr_ch = ch; wr_period = 16'(p); wr_duty = 16'(d);
      cyc();
      wr_en = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; enable = 0; wr_en = 0; wr_ch = 0; wr_period = 0; wr_duty = 0;
      repeat (3) cyc();
      n_cmp++;
      if ({pwm_a, ps_a, err_a, pwm_b, ps_b, err_b} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got %b required 0", {pwm_a, ps_a, err_a, pwm_b, ps_b, err_b});
      end
      rst_n = 1;
      cyc();
      n_cmp++;
      if ({pwm_a, ps_a, pwm_b, ps_b} !== '0) begin
         n_bad++;
         $display("FAIL disabled_after_reset: got %b required 0", {pwm_a, ps_a, pwm_b, ps_b});
      end
   endtask

   task automatic test_basic();
      logic [29:0] op, os, ob, ep, es;
      wr(0, 10, 4);
      cyc();
      enable = 1;
      for (int i = 0; i < 30; i++) begin
         cyc();
         op[i] = pwm_a[0]; os[i] = ps_a[0]; ob[i] = pwm_b[0];
         ep[i] = (i % 10) < 4; es[i] = (i % 10) == 0;
      end
      n_cmp++;
      if (op !== ep) begin n_bad++; $display("FAIL basic_pwm: got %b required %b", op, ep); end
      n_cmp++;
      if (os !== es) begin n_bad++; $display("FAIL basic_start: got %b required %b", os, es); end
      n_cmp++;
      if (ob !== ep) begin n_bad++; $display("FAIL basic_pwm_ramped_inst: got %b required %b", ob, ep); end
   endtask

   task automatic test_midwrite();
      logic [29:0] o, e;
      logic [19:0] o2, e2;
      wr_ch = 0; wr_period = 10; wr_duty = 7;
      for (int i = 0; i < 30; i++) begin
         cyc();
         o[i] = pwm_a[0];
         e[i] = (i < 10) ? (i < 4) : ((i % 10) < 7);
         wr_en = (i == 2);
      end
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL midperiod_write: got %b required %b", o, e); end
      for (int i = 0; i < 20; i++) begin
         cyc();
         o2[i] = pwm_a[0];
         e2[i] = (i < 10) ? (i < 7) : ((i % 10) < 5);
         wr_en = (i == 1 || i == 4);
         wr_duty = (i == 1) ? 16'd3 : 16'd5;
      end
      wr_en = 0;
      n_cmp++;
      if (o2 !== e2) begin n_bad++; $display("FAIL last_write_wins: got %b required %b", o2, e2); end
   endtask

   task automatic test_edges();
      int per[4] = '{10, 10, 0, 1};
      int dut[4] = '{12, 0, 5, 1};
      int ehi[4] = '{20, 0, 0, 20};
      int est[4] = '{2, 2, 0, 20};
      int hi, st;
      for (int t = 0; t < 4; t++) begin
         wr(0, per[t], dut[t]);
         repeat (12) cyc();
         hi = 0; st = 0;
         for (int i = 0; i < 20; i++) begin
            cyc();
            hi += int'(pwm_a[0]); st += int'(ps_a[0]);
         end
         n_cmp++;
         if (hi != ehi[t]) begin n_bad++; $display("FAIL edge_high p=%0d d=%0d: got %0d required %0d", per[t], dut[t], hi, ehi[t]); end
         n_cmp++;
         if (st != est[t]) begin n_bad++; $display("FAIL edge_starts p=%0d d=%0d: got %0d required %0d", per[t], dut[t], st, est[t]); end
      end
   endtask

   task automatic test_ramp();
      int exp_hi[2][4] = '{'{2, 4, 6, 7}, '{5, 3, 1, 0}};
      int hi;
      bit found;
      for (int ph = 0; ph < 2; ph++) begin
         wr(1, 10, ph == 0 ? 7 : 0);
         found = 0;
         for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            found = ps_b[1];
         end
         n_cmp++;
         if (!found) begin n_bad++; $display("FAIL ramp_sync: got no period start required one within 12 cycles"); end
         for (int p = 0; p < 4; p++) begin
            hi = int'(pwm_b[1]);
            repeat (9) begin
               cyc();
               hi += int'(pwm_b[1]);
            end
            n_cmp++;
            if (hi != exp_hi[ph][p]) begin n_bad++; $display("FAIL ramp_period ph=%0d p=%0d: got %0d high required %0d", ph, p, hi, exp_hi[ph][p]); end
            cyc();
         end
      end
   endtask

   task automatic test_bad_ch();
      int hi0, st0, hi2, st2;
      wr(3, 0, 0);
      n_cmp++;
      if ({err_a, err_b} !== 2'b11) begin n_bad++; $display("FAIL wr_err_pulse: got %b required 11", {err_a, err_b}); end
      cyc();
      n_cmp++;
      if ({err_a, err_b} !== 2'b00) begin n_bad++; $display("FAIL wr_err_clear: got %b required 00", {err_a, err_b}); end
      for (int i = 0; i < 15; i++) begin
         cyc();
         n_cmp++;
         if ({pwm_a, ps_a, pwm_b, ps_b} !== {m_pwm[0], m_ps[0], m_pwm[1], m_ps[1]}) begin
            n_bad++;
            $display("FAIL bad_ch_no_effect cyc=%0d: got %b required %b", i, {pwm_a, ps_a, pwm_b, ps_b}, {m_pwm[0], m_ps[0], m_pwm[1], m_ps[1]});
         end
      end
      wr(0, 10, 3);
      wr(2, 5, 2);
      repeat (12) cyc();
      hi0 = 0; st0 = 0; hi2 = 0; st2 = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         hi0 += int'(pwm_a[0]); st0 += int'(ps_a[0]);
         hi2 += int'(pwm_a[2]); st2 += int'(ps_a[2]);
      end
      n_cmp++;
      if ({hi0, st0, hi2, st2} != {32'd6, 32'd2, 32'd8, 32'd4}) begin
         n_bad++;
         $display("FAIL independence: got hi0=%0d st0=%0d hi2=%0d st2=%0d required 6 2 8 4", hi0, st0, hi2, st2);
      end
   endtask

   task automatic test_enable();
      int hi, st;
      bit found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         cyc();
         found = ps_a[0];
      end
      n_cmp++;
      if (!found) begin n_bad++; $display("FAIL enable_sync: got no period start required one within 12 cycles"); end
      cyc();
      enable = 0;
      cyc();
      n_cmp++;
      if ({pwm_a, ps_a, pwm_b, ps_b} !== '0) begin n_bad++; $display("FAIL disable_next_edge: got %b required 0", {pwm_a, ps_a, pwm_b, ps_b}); end
      repeat (4) cyc();
      n_cmp++;
      if ({pwm_a, ps_a, pwm_b, ps_b} !== '0) begin n_bad++; $display("FAIL disable_hold: got %b required 0", {pwm_a, ps_a, pwm_b, ps_b}); end
      enable = 1;
      cyc();
      n_cmp++;
      if ({ps_a, pwm_a} !== 6'b111_101) begin n_bad++; $display("FAIL reenable_fresh: got %b required 111101", {ps_a, pwm_a}); end
      hi = int'(pwm_a[0]);
      repeat (9) begin
         cyc();
         hi += int'(pwm_a[0]);
      end
      n_cmp++;
      if (hi != 3) begin n_bad++; $display("FAIL reenable_duty: got %0d high required 3", hi); end
      cyc();
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if ({pwm_a, ps_a, pwm_b, ps_b} !== '0) begin n_bad++; $display("FAIL async_reset: got %b required 0", {pwm_a, ps_a, pwm_b, ps_b}); end
      @(negedge clk);
      rst_n = 1;
      hi = 0; st = 0;
      repeat (25) begin
         cyc();
         hi += $countones({pwm_a, pwm_b});
         st += int'(ps_a[0]);
      end
      n_cmp++;
      if (hi != 0) begin n_bad++; $display("FAIL post_reset_low: got %0d high cycles required 0", hi); end
      n_cmp++;
      if (st != 3) begin n_bad++; $display("FAIL post_reset_period: got %0d starts required 3", st); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         enable    = ($urandom_range(0, 19) != 0);
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_ch     = 2'($urandom_range(0, 3));
         wr_period = 16'($urandom_range(0, 12));
         wr_duty   = 16'($urandom_range(0, 14));
         cyc();
         n_cmp++;
         if ({pwm_a, ps_a, err_a} !== {m_pwm[0], m_ps[0], m_err[0]}) begin
            n_bad++;
            $display("FAIL random_direct cyc=%0d: got %b required %b", i, {pwm_a, ps_a, err_a}, {m_pwm[0], m_ps[0], m_err[0]});
         end
         n_cmp++;
         if ({pwm_b, ps_b, err_b} !== {m_pwm[1], m_ps[1], m_err[1]}) begin
            n_bad++;
            $display("FAIL random_ramped cyc=%0d: got %b required %b", i, {pwm_b, ps_b, err_b}, {m_pwm[1], m_ps[1], m_err[1]});
         end
      end
      wr_en = 0;
      enable = 1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_midwrite();
      test_edges();
      test_ramp();
      test_bad_ch();
      test_enable();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/pwm_multichannel_ctrl.md
Name: pwm_multichannel_ctrl

Overview:
- Parametrised N-channel PWM generator. Successor to the fixed three-channel, fixed-period PWM block.
- Each channel has its own period and duty, written over a simple register-write port by the control logic.
- Duty and period changes are double-buffered and only take effect at a period boundary, so no output pulse is ever truncated or extended.
- An optional per-boundary duty slew limit gives soft start/stop for ESC channels. Outputs drive servo/ESC pins directly.

Parameters:
- NUM_CH, 3: number of PWM channels.
- CH_W, 2: width of the channel select; must satisfy 2**CH_W >= NUM_CH.
- CNT_W, 16: width of the period, duty and counter values.
- DEF_PERIOD, 10: reset value of every pending period register.
- RAMP_STEP, 0: maximum change of active duty per period boundary; 0 means changes apply immediately.

Ports:
- clk, in, 1: system clock (12 MHz on board).
- rst_n, in, 1: reset. Asynchronous, active-low.
- enable, in, 1: global run enable.
- wr_en, in, 1: write strobe, one cycle per write.
- wr_ch, in, CH_W: target channel.
- wr_period, in, CNT_W: new period in clk cycles.
- wr_duty, in, CNT_W: new high time in clk cycles.
- wr_err, out, 1: registered one-cycle pulse when wr_ch >= NUM_CH.
- pwm_out, out, NUM_CH: PWM outputs, registered.
- period_start, out, NUM_CH: registered one-cycle pulse when a channel's counter restarts at 0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all counters = 0; active period = 0; active duty = 0.
  - pending period = DEF_PERIOD; pending duty = 0.
  - pwm_out = 0, period_start = 0, wr_err = 0.
- Per-channel state: cnt, act_period, act_duty, pend_period, pend_duty.
- Write port:
  - If wr_en=1 and wr_ch < NUM_CH, pend_period and pend_duty of wr_ch load at the next edge.
  - Last write before a boundary wins.
  - If wr_ch >= NUM_CH, no state changes and wr_err=1 for the following cycle.
- Boundary for channel i is true when any of these holds:
  - enable=0;
  - act_period=0;
  - cnt = act_period-1.
- At an edge where the boundary is true:
  - cnt <= 0; act_period <= pend_period;
  - act_duty <= ramped(pend_duty);
  - period_start[i] <= enable.
- Otherwise: cnt <= cnt+1; period_start[i] <= 0.
- ramped(target):
  - If RAMP_STEP=0 or enable=0, result = target.
  - Else result = act_duty moved toward target by at most RAMP_STEP, no overshoot.
  - Arithmetic uses CNT_W+1 bits with saturation at 0 and at 2**CNT_W-1.
- Write coinciding with a boundary: the boundary loads the pre-write pending values; the new values apply at the next boundary.
- Output:
  - pwm_out[i] <= enable & (next_act_period != 0) & (next_cnt < next_act_duty), so the output is aligned with the counter, with no extra latency.
  - duty >= period gives a constant high (100%).
  - duty = 0 gives a constant low.
  - period = 0 holds the output low and the counter at 0.
- enable=0: all outputs low, counters held at 0, pending registers still writable, active registers track pending every cycle.
- First edge with enable=1: cnt=0 begins the first period with the current active values, and period_start pulses.
- Reset asserted mid-period: all outputs go to 0 immediately (asynchronous). Pending writes are lost.
- Channels are fully independent; there is no phase alignment between channels.

Test Plan:
- Basic duty: reset, enable=1, write ch0 period=10 duty=4 → after the first boundary, pwm_out[0] is high 4 cycles and low 6, repeating. period_start[0] pulses every 10 cycles coincident with the rising output.
- Mid-period write: write ch0 duty=7 at cnt=2 → current period still shows 4 high; the next period shows 7 high. Write ch0 duty=3 then duty=5 within one period → only 5 is applied.
- Edge values: period=10 duty=12 → constant high. Duty=0 → constant low. Period=0 → constant low, no period_start pulses. Period=1 duty=1 → constant high, period_start every cycle.
- Ramp (RAMP_STEP=2 instance): ch1 period=10, duty written 0→7 → successive periods show 2, 4, 6, 7 high cycles. Writing duty back to 0 → 5, 3, 1, 0.
- Bad channel and independence (NUM_CH=3): write wr_ch=3 → wr_err pulses one cycle and channels 0-2 are unchanged. Ch0 period=10 and ch2 period=5 run concurrently with correct periods.
- Enable and reset: drop enable mid-period → all outputs low on the next edge. Re-enable → fresh period from cnt=0. Assert rst_n=0 mid-high-pulse → pwm_out=0 immediately; after release, pending period=10 and duty=0, so the output stays low.
